// File: rtl/md_issue_ctrl.sv
// HI/LO multiply/divide issue controller: tracks unit occupancy, stalls D-stage HI/LO users, handles flush abort.
// Optional MD_DIVZERO_FAST_EN: a divide by zero occupies the unit for a single RUN cycle.
module md_issue_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [2:0] e_md_op,
  input  logic       e_rt_zero,
  input  logic       d_use_hilo,
  input  logic       int_flush,
  output logic [1:0] md_start,
  output logic       md_signed,
  output logic [1:0] md_wr,
  output logic       md_abort,
  output logic       stall_d,
  output logic       busy,
  output logic       protocol_err
);

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_e;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       perr_q, perr_d;

  logic       is_mul, is_div, is_mt, idle, issue;
  logic [3:0] div_lat;

  assign is_mul = (e_md_op == 3'd1) || (e_md_op == 3'd2);
  assign is_div = (e_md_op == 3'd3) || (e_md_op == 3'd4);
  assign is_mt  = (e_md_op == 3'd5) || (e_md_op == 3'd6);
  assign idle   = (state_q == IDLE);
  assign issue  = !reset && idle && e_valid && (is_mul || is_div) && !int_flush;

`ifdef MD_DIVZERO_FAST_EN
  assign div_lat = e_rt_zero ? 4'd1 : DIV_LAT;
`else
  assign div_lat = DIV_LAT;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    perr_d    = perr_q;
    md_start  = 2'b00;
    md_signed = 1'b0;
    md_wr     = 2'b00;
    md_abort  = 1'b0;
    if (idle) begin
      if (issue) begin
        md_start  = is_mul ? 2'b01 : 2'b10;
        md_signed = (e_md_op == 3'd1) || (e_md_op == 3'd3);
        state_d   = is_mul ? RUN_MUL : RUN_DIV;
        cnt_d     = is_mul ? MUL_LAT : div_lat;
        first_d   = 1'b1;
      end else if (!reset && e_valid && is_mt && !int_flush) begin
        md_wr = (e_md_op == 3'd5) ? 2'b01 : 2'b10;
      end
    end else begin
      if (e_valid && (is_mul || is_div || is_mt)) perr_d = 1'b1;
      // Only the first RUN cycle can be flushed: the issuer is then in M and gets cancelled.
      if (first_q && int_flush) begin
        md_abort = !reset;
        state_d  = IDLE;
        cnt_d    = 4'd0;
      end else if (cnt_q <= 4'd1) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      first_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      perr_q  <= perr_d;
    end
  end

  assign busy         = !reset && (!idle || issue);
  assign stall_d      = d_use_hilo && busy;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Cycle-by-cycle vector table for md_issue_ctrl, expected outputs queued as a scoreboard.
module tb_md_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       e_valid = 1'b0, e_rt_zero = 1'b0, d_use_hilo = 1'b0, int_flush = 1'b0;
  logic [2:0] e_md_op = 3'd0;
  logic [1:0] md_start, md_wr;
  logic       md_signed, md_abort, stall_d, busy, protocol_err;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op), .e_rt_zero(e_rt_zero),
    .d_use_hilo(d_use_hilo), .int_flush(int_flush), .md_start(md_start), .md_signed(md_signed),
    .md_wr(md_wr), .md_abort(md_abort), .stall_d(stall_d), .busy(busy), .protocol_err(protocol_err)
  );

`ifdef MD_DIVZERO_FAST_EN
  localparam int DZ_RUN = 1;
`else
  localparam int DZ_RUN = 10;
`endif

  typedef struct packed {
    logic       rst, ev;
    logic [2:0] op;
    logic       rz, du, fl;
    logic [1:0] st;
    logic       sg;
    logic [1:0] wr;
    logic       ab, sd, bz, pe;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, ev, input logic [2:0] op, input logic rz, du, fl,
                     input logic [1:0] st, input logic sg, input logic [1:0] wr,
                     input logic ab, sd, bz, pe);
    vec_t v;
    v = '{rst, ev, op, rz, du, fl, st, sg, wr, ab, sd, bz, pe};
    vecs.push_back(v);
  endtask

  task automatic idle_n(input int n, input logic du, bz, pe);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, du, 0, 0, 0, 0, 0, du & bz, bz, pe);
  endtask

  initial begin
    // reset dominates a live MULT request
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_n(1, 0, 0, 0);
    // MULT with d_use_hilo held: stall T..T+5
    add(0, 1, 1, 0, 1, 0, 2'b01, 1, 0, 0, 1, 1, 0);
    idle_n(5, 1, 1, 0);
    idle_n(1, 1, 0, 0);
    // MT writes, reserved/none opcodes, flush suppression
    add(0, 1, 6, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle_n(1, 0, 0, 0);
    // DIVU by zero
    add(0, 1, 4, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0);
    idle_n(DZ_RUN, 0, 1, 0);
    idle_n(1, 0, 0, 0);
    // DIV with nonzero divisor: always 10 RUN cycles
    add(0, 1, 3, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 0);
    idle_n(10, 0, 1, 0);
    idle_n(1, 0, 0, 0);
    // DIV flushed in first RUN cycle
    add(0, 1, 3, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    idle_n(1, 0, 0, 0);
    // DIV flushed in second RUN cycle: ignored
    add(0, 1, 3, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1, 0);
    idle_n(1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle_n(8, 0, 1, 0);
    idle_n(1, 0, 0, 0);
    // MTHI and DIV in E during RUN_MUL: nothing issued, sticky protocol_err
    add(0, 1, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 1, 0);
    add(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle_n(3, 0, 1, 1);
    idle_n(1, 0, 0, 1);
    add(0, 1, 6, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1);
    add(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_n(1, 0, 0, 0);
    // reset at T+3 of MULTU, then MULT issues normally
    add(0, 1, 2, 0, 1, 0, 2'b01, 0, 0, 0, 1, 1, 0);
    idle_n(2, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_n(1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 1, 0);
    idle_n(5, 0, 1, 0);
    idle_n(1, 0, 0, 0);

    foreach (vecs[i]) begin
      vec_t v, e;
      logic [10:0] got, req;
      v = vecs[i];
      @(posedge clk);
      #1;
      reset = v.rst; e_valid = v.ev; e_md_op = v.op; e_rt_zero = v.rz;
      d_use_hilo = v.du; int_flush = v.fl;
      sb.push_back(v);
      @(negedge clk);
      e   = sb.pop_front();
      got = {md_start, md_signed, md_wr, md_abort, stall_d, busy, protocol_err};
      req = {e.st, e.sg, e.wr, e.ab, e.sd, e.bz, e.pe};
      n_checks++;
      if (got !== req) begin
        n_fail++;
        $display("FAIL vec%0d {start,signed,wr,abort,stall,busy,perr}: got %b expected %b", i, got, req);
      end
      n_checks++;
      if ((md_start != 2'b00) + (md_wr != 2'b00) + md_abort > 1) begin
        n_fail++;
        $display("FAIL excl%0d start/wr/abort overlap: got %b/%b/%b expected at most one", i, md_start, md_wr, md_abort);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; the only clock, rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: e_valid  in  1  E-stage instruction valid.
REQ-004 SHALL have port: e_md_op  in  3  E-stage HI/LO class: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
REQ-005 SHALL have port: e_rt_zero  in  1  E-stage divisor equals 0.
REQ-006 SHALL have port: d_use_hilo  in  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-007 SHALL have port: int_flush  in  1  exception/interrupt flush of E and M stages.
REQ-008 SHALL have ports: md_start  out  2  unit command (01 mult, 10 div, 00 none); md_signed  out  1; md_wr  out  2  (01 write HI, 10 write LO).
REQ-009 SHALL have ports: md_abort  out  1  restore HI/LO and cancel; stall_d  out  1; busy  out  1; protocol_err  out  1  sticky.

Function
REQ-010 SHALL implement FSM states IDLE, RUN_MUL, RUN_DIV and a 4-bit down-counter cnt.
REQ-011 An "issue" SHALL occur in IDLE when e_valid=1, e_md_op is 1-4 and int_flush=0.
REQ-012 On issue, md_start and md_signed SHALL be driven combinationally in the same cycle: md_signed=1 for MULT/DIV only.
REQ-013 On issue, the next state SHALL be RUN_MUL with cnt=5 (ops 1/2) or RUN_DIV with cnt=10 (ops 3/4).
REQ-014 In RUN_*, cnt SHALL decrement each cycle; the state SHALL return to IDLE on the edge where cnt==1.
REQ-015 Total occupancy: issue cycle T, then RUN cycles T+1..T+LAT; the unit is free from cycle T+LAT+1.
REQ-016 busy SHALL equal (state!=IDLE) OR issue.
REQ-017 stall_d SHALL equal d_use_hilo AND busy; no other term.
REQ-018 In IDLE with e_valid=1, e_md_op=5/6 and int_flush=0, md_wr SHALL be 01/10 for exactly that cycle; no state change.
REQ-019 int_flush in the issue cycle SHALL suppress md_start and md_wr, with no state change.
REQ-020 int_flush in the first RUN cycle (cnt==LAT) SHALL assert md_abort for one cycle and force IDLE next edge; this flushes the issuer, which is then in M.
REQ-021 int_flush in any later RUN cycle SHALL be ignored; the operation completes.
REQ-022 e_valid=1 with e_md_op 1-6 while in RUN_* SHALL issue nothing and SHALL set protocol_err until reset.
REQ-023 md_start, md_wr and md_abort SHALL never be asserted simultaneously.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, cnt=0 and protocol_err=0, and SHALL take priority over every other event, including mid-RUN.
REQ-025 While reset=1, md_start, md_wr, md_abort, stall_d and busy SHALL be 0, independent of inputs.

Configuration
REQ-026 Macro MD_DIVZERO_FAST_EN: when defined, a DIV/DIVU issue with e_rt_zero=1 SHALL load cnt=1 (RUN_DIV lasts one cycle) and md_start SHALL still be 10.
REQ-027 Without MD_DIVZERO_FAST_EN, e_rt_zero SHALL be ignored and all divides SHALL take 10 RUN cycles.

Verification
REQ-028 MULT issue at T with d_use_hilo=1 held -> md_start=01 and md_signed=1 at T; stall_d=1 for T..T+5; stall_d=0 at T+6.
REQ-029 DIVU issue, e_rt_zero=1 -> md_start=10, md_signed=0; busy for 11 cycles without the macro; busy for 2 cycles (T, T+1) with the macro.
REQ-030 DIV issue at T, int_flush=1 at T+1 -> md_abort=1 at T+1 only, state IDLE at T+2; int_flush at T+2 instead -> no abort, busy through T+10.
REQ-031 MTLO at E while IDLE -> md_wr=10 for one cycle; MTHI at E in RUN_MUL -> md_wr=00 and protocol_err=1 until reset.
REQ-032 reset at T+3 of MULTU -> busy=0 and stall_d=0 at T+3, state IDLE at T+4; next MULT issues normally.
